instr_packer: RTL

INSTR_PACKER -- requirements
Module: instr_packer

---
 rtl/structures.sv | 38 +++
 rtl/instr_field_pack.sv | 36 +++
 rtl/instr_packer.sv | 89 ++++++++
 3 files changed

// File: rtl/structures.sv
// Shared types for the instruction packer: selector struct, format codes,
// field placement constants and the control FSM encoding.
package structures;

  typedef struct packed {
    logic CB_type;
    logic B_type;
    logic D_type;
  } format_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FMT_I  = 2'b00,
    FMT_D  = 2'b01,
    FMT_B  = 2'b10,
    FMT_CB = 2'b11
  } fmt_code_t;

  localparam logic [5:0] I_LSB    = 6'd10;
  localparam logic [5:0] I_WIDTH  = 6'd12;
  localparam logic [5:0] D_LSB    = 6'd12;
  localparam logic [5:0] D_WIDTH  = 6'd9;
  localparam logic [5:0] B_LSB    = 6'd0;
  localparam logic [5:0] B_WIDTH  = 6'd26;
  localparam logic [5:0] CB_LSB   = 6'd5;
  localparam logic [5:0] CB_WIDTH = 6'd19;

  // Multi-hot selectors collapse onto the two-bit code, so CB wins over D|B.
  function automatic fmt_code_t decode_fmt(input format_type f);
    return fmt_code_t'({f.B_type | f.CB_type, f.D_type | f.CB_type});
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational immediate insertion and signed range check for one instruction.
module instr_field_pack
  import structures::*;
(
  input  format_type  sel_fmt,
  input  logic [31:0] base_word,
  input  logic [63:0] imm_value,
  output logic [31:0] instr,
  output logic        range_err
);

  logic [5:0]  lsb;
  logic [5:0]  width;
  logic [31:0] mask;
  logic [63:0] upper;

  always_comb begin
    lsb   = I_LSB;
    width = I_WIDTH;
    case (decode_fmt(sel_fmt))
      FMT_D:   begin lsb = D_LSB;  width = D_WIDTH;  end
      FMT_B:   begin lsb = B_LSB;  width = B_WIDTH;  end
      FMT_CB:  begin lsb = CB_LSB; width = CB_WIDTH; end
      default: begin lsb = I_LSB;  width = I_WIDTH;  end
    endcase
  end

  always_comb begin
    mask  = (32'd1 << width) - 32'd1;
    instr = (base_word & ~(mask << lsb)) | ((imm_value[31:0] & mask) << lsb);
    // Bits above the field sign bit must all replicate it for the value to fit.
    upper = $unsigned($signed(imm_value) >>> (width - 6'd1));
    range_err = !((upper == '0) || (upper == '1));
  end

endmodule

// File: rtl/instr_packer.sv
// Streams instructions through the field packer with a one-deep output
// register, address counter, saturating error count and IDLE/RUN/HALT control.
module instr_packer
  import structures::*;
#(
  parameter bit          HALT_ON_ERR = 1'b1,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  format_type  sel_fmt,
  input  logic [31:0] base_word,
  input  logic [63:0] imm_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_addr,
  output logic        range_err,
  output logic [15:0] err_count,
  output logic [1:0]  state_o
);

  state_t      state, state_nxt;
  logic [63:0] addr_cnt;
  logic [31:0] pack_instr;
  logic        pack_err;
  logic        accept;

  instr_field_pack u_pack (
    .sel_fmt   (sel_fmt),
    .base_word (base_word),
    .imm_value (imm_value),
    .instr     (pack_instr),
    .range_err (pack_err)
  );

  // Handshakes: a word moves when valid && ready on a rising edge; out_* hold
  // while out_valid && !out_ready, and intake only runs in RUN.
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign state_o  = state;

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (accept && pack_err && HALT_ON_ERR) state_nxt = HALT;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_addr  <= BASE_ADDR;
      range_err <= 1'b0;
      err_count <= 16'h0;
      addr_cnt  <= BASE_ADDR;
    end else if (clr) begin
      out_valid <= 1'b0;
      err_count <= 16'h0;
      addr_cnt  <= BASE_ADDR;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= pack_instr;
      out_addr  <= addr_cnt;
      range_err <= pack_err;
      addr_cnt  <= addr_cnt + 64'd4;
      if (pack_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
